// File: rtl/if_prefetch_buffer_if.sv
// Bundle of the instruction-memory bus and the IF-stage delivery handshake.
// Handshake: an entry is transferred on a rising edge when inst_valid and
// inst_ready are both 1. inst_valid never depends on inst_ready. The head
// entry stays stable while inst_valid=1 and inst_ready=0, unless a redirect
// or reset flushes the queue. Buses are big-endian, so index 0 is the MSB.
interface if_prefetch_buffer_if;
  logic        fetch_enable;
  logic        redirect;
  logic [0:31] redirect_addr;
  logic [0:31] imem_addr;
  logic [0:31] imem_instr;
  logic [0:31] inst_out;
  logic [0:31] pc_out;
  logic        inst_valid;
  logic        inst_ready;

  // slave: the prefetch buffer itself
  modport slave (
    input  fetch_enable, redirect, redirect_addr, imem_instr, inst_ready,
    output imem_addr, inst_out, pc_out, inst_valid
  );

  // master: the surrounding core (IF stage, control, instruction memory)
  modport master (
    output fetch_enable, redirect, redirect_addr, imem_instr, inst_ready,
    input  imem_addr, inst_out, pc_out, inst_valid
  );
endinterface

// File: rtl/if_prefetch_buffer.sv
// Instruction prefetch queue. It fetches one word per cycle from its own PC
// into a circular FIFO and delivers {pc, instr} pairs to IF. A redirect
// flushes the queue and restarts fetch at an aligned target.
module if_prefetch_buffer #(
  parameter int          DEPTH    = 4,
  parameter logic [0:31] RESET_PC = 32'h0000_0000
) (
  input  logic                       clock,
  input  logic                       reset,
  if_prefetch_buffer_if.slave        bus,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [0:31]   fetch_pc_q, fetch_pc_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  // Entry storage is not reset; it only holds meaning while count_q covers it.
  logic [0:31] mem_pc_q    [DEPTH];
  logic [0:31] mem_instr_q [DEPTH];

  logic pop;
  logic push;

  // Outputs come from registered state only, never from inst_ready.
  assign bus.inst_valid = (count_q != '0);
  assign bus.inst_out   = mem_instr_q[rd_ptr_q];
  assign bus.pc_out     = mem_pc_q[rd_ptr_q];
  assign bus.imem_addr  = fetch_pc_q;
  assign count          = count_q;

  // A pop completes even in a redirect cycle. A full queue can still accept
  // a push when a pop frees the head slot on the same edge.
  assign pop  = bus.inst_valid & bus.inst_ready;
  assign push = bus.fetch_enable & ~bus.redirect &
                ((count_q < CW'(DEPTH)) | pop);

  // Next-state for the fetch PC, pointers and occupancy; redirect wins.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (bus.redirect) begin
      fetch_pc_d = {bus.redirect_addr[0:29], 2'b00};
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (push) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
        wr_ptr_d   = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      if (push && !pop) begin
        count_d = count_q + CW'(1);
      end else if (pop && !push) begin
        count_d = count_q - CW'(1);
      end
    end
  end

  // Control state with an asynchronous flush on reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fetch_pc_q <= RESET_PC;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // Capture the fetched word together with its address at the write slot.
  always_ff @(posedge clock) begin
    if (push) begin
      mem_pc_q[wr_ptr_q]    <= fetch_pc_q;
      mem_instr_q[wr_ptr_q] <= bus.imem_instr;
    end
  end
endmodule

// File: tb/tb_if_prefetch_buffer.sv
// Bench for if_prefetch_buffer: a table of per-edge vectors, followed by
// hand-written sequences for streaming from reset and an asynchronous reset.
module tb_if_prefetch_buffer;
  localparam int DEPTH = 4;

  logic       clock;
  logic       reset;
  logic [2:0] count;
  int         checks;
  int         errors;

  if_prefetch_buffer_if bus ();

  // The instruction memory returns the address plus a fixed tag, combinationally.
  assign bus.imem_instr = bus.imem_addr + 32'h1000_0000;

  if_prefetch_buffer #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave),
    .count (count)
  );

  // clock / reset block
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        fe;
    logic        rd;
    logic [0:31] ra;
    logic        rdy;
    logic        ev;
    logic [2:0]  ecnt;
    logic [0:31] epc;
    logic [0:31] eaddr;
    logic        chk_head;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic fe, logic rd, logic [0:31] ra, logic rdy,
                              logic ev, logic [2:0] ecnt, logic [0:31] epc,
                              logic [0:31] eaddr, logic chk_head);
    vec_t v;
    v.fe = fe; v.rd = rd; v.ra = ra; v.rdy = rdy;
    v.ev = ev; v.ecnt = ecnt; v.epc = epc; v.eaddr = eaddr;
    v.chk_head = chk_head;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic drive(input logic fe, input logic rd, input logic [0:31] ra,
                       input logic rdy);
    bus.fetch_enable  = fe;
    bus.redirect      = rd;
    bus.redirect_addr = ra;
    bus.inst_ready    = rdy;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    reset = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("reset_valid", {31'd0, bus.inst_valid}, 32'd0);
    check("reset_count", {29'd0, count}, 32'd0);
    check("reset_imem_addr", bus.imem_addr, 32'h0);

    // fill, full, push+pop while full, frozen fetch, redirect, streaming, wrap
    vecs.push_back(mk(1, 0, 32'h0, 0, 1, 1, 32'h0, 32'h4, 1));
    vecs.push_back(mk(1, 0, 32'h0, 0, 1, 2, 32'h0, 32'h8, 1));
    vecs.push_back(mk(1, 0, 32'h0, 0, 1, 3, 32'h0, 32'hC, 1));
    vecs.push_back(mk(1, 0, 32'h0, 0, 1, 4, 32'h0, 32'h10, 1));
    vecs.push_back(mk(1, 0, 32'h0, 0, 1, 4, 32'h0, 32'h10, 1));
    vecs.push_back(mk(1, 0, 32'h0, 1, 1, 4, 32'h4, 32'h14, 1));
    vecs.push_back(mk(0, 0, 32'h0, 0, 1, 4, 32'h4, 32'h14, 1));
    vecs.push_back(mk(0, 0, 32'h0, 1, 1, 3, 32'h8, 32'h14, 1));
    vecs.push_back(mk(1, 1, 32'h103, 1, 0, 0, 32'h0, 32'h100, 0));
    vecs.push_back(mk(1, 0, 32'h0, 0, 1, 1, 32'h100, 32'h104, 1));
    vecs.push_back(mk(1, 0, 32'h0, 1, 1, 1, 32'h104, 32'h108, 1));
    vecs.push_back(mk(1, 0, 32'h0, 1, 1, 1, 32'h108, 32'h10C, 1));
    vecs.push_back(mk(1, 1, 32'hFFFF_FFF8, 1, 0, 0, 32'h0, 32'hFFFF_FFF8, 0));
    vecs.push_back(mk(1, 0, 32'h0, 1, 1, 1, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 1));
    vecs.push_back(mk(1, 0, 32'h0, 1, 1, 1, 32'hFFFF_FFFC, 32'h0, 1));
    vecs.push_back(mk(1, 0, 32'h0, 1, 1, 1, 32'h0, 32'h4, 1));
    vecs.push_back(mk(1, 0, 32'h0, 1, 1, 1, 32'h4, 32'h8, 1));
    vecs.push_back(mk(1, 0, 32'h0, 1, 1, 1, 32'h8, 32'hC, 1));
    vecs.push_back(mk(1, 0, 32'h0, 1, 1, 1, 32'hC, 32'h10, 1));
    vecs.push_back(mk(0, 0, 32'h0, 1, 0, 0, 32'h0, 32'h10, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].fe, vecs[i].rd, vecs[i].ra, vecs[i].rdy);
      step();
      check($sformatf("v%0d_valid", i), {31'd0, bus.inst_valid}, {31'd0, vecs[i].ev});
      check($sformatf("v%0d_count", i), {29'd0, count}, {29'd0, vecs[i].ecnt});
      check($sformatf("v%0d_imem_addr", i), bus.imem_addr, vecs[i].eaddr);
      if (vecs[i].chk_head) begin
        check($sformatf("v%0d_pc_out", i), bus.pc_out, vecs[i].epc);
        check($sformatf("v%0d_inst_out", i), bus.inst_out,
              vecs[i].epc + 32'h1000_0000);
      end
    end

    // Fill to full, then drop reset between edges: the flush is immediate.
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    repeat (4) step();
    check("pre_async_count", {29'd0, count}, 32'd4);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("async_valid", {31'd0, bus.inst_valid}, 32'd0);
    check("async_count", {29'd0, count}, 32'd0);
    check("async_imem_addr", bus.imem_addr, 32'h0);
    drive(1'b1, 1'b0, 32'h0, 1'b1);
    step();
    check("in_reset_count", {29'd0, count}, 32'd0);
    @(negedge clock);
    reset = 1'b1;

    // Streaming from reset release: one instruction per cycle, occupancy 1.
    for (int k = 0; k < 6; k++) begin
      step();
      check($sformatf("stream%0d_valid", k), {31'd0, bus.inst_valid}, 32'd1);
      check($sformatf("stream%0d_count", k), {29'd0, count}, 32'd1);
      check($sformatf("stream%0d_pc_out", k), bus.pc_out, 32'(k * 4));
      check($sformatf("stream%0d_inst_out", k), bus.inst_out,
            32'(k * 4) + 32'h1000_0000);
    end

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/if_prefetch_buffer.md
# if_prefetch_buffer

Instruction prefetch queue between the instruction memory and the processor's IF stage. It drives the instruction-memory address from its own fetch PC, captures one word per cycle into a small circular FIFO, and hands instructions and their PCs to IF with a valid/ready handshake. A redirect input flushes the queue and restarts fetch at a new address.

## Interface
- DEPTH, 4, FIFO entries; power of two, at least 2
- RESET_PC, 32'h0000_0000, fetch address after reset
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (0 = in reset)
- fetch_enable  in  1  1 = pushes permitted; 0 = fetch PC and FIFO writes frozen
- redirect  in  1  flush queue and restart fetch at redirect_addr
- redirect_addr  in  [0:31]  new fetch address; bits [30:31] ignored (treated as 0)
- imem_addr  out  [0:31]  address to instruction memory; equals fetch_pc
- imem_instr  in  [0:31]  instruction word at imem_addr, combinational, same cycle
- inst_out  out  [0:31]  instruction at FIFO head
- pc_out  out  [0:31]  address of inst_out
- inst_valid  out  1  FIFO non-empty
- inst_ready  in  1  IF stage accepts head this cycle
- count  out  clog2(DEPTH+1)  current occupancy

## Operation
- State: fetch_pc (32b), wr_ptr and rd_ptr (clog2(DEPTH) bits, wrap mod DEPTH), count, and DEPTH entries of {pc, instr}.
- pop = inst_valid & inst_ready. A handshake completes whenever both are high, including in a redirect cycle.
- push = fetch_enable & !redirect & (count < DEPTH | pop). On push, the entry at wr_ptr gets {fetch_pc, imem_instr}, wr_ptr increments, and fetch_pc becomes fetch_pc + 4 (mod 2^32; 32'hFFFF_FFFC wraps to 0).
- Count update: push only, +1; pop only, -1; both, unchanged; neither, unchanged.
- Full: count == DEPTH. A push still happens if a pop occurs the same cycle. Otherwise fetch_pc holds and imem_addr is stable.
- Empty: inst_valid = 0. inst_out and pc_out show the stale entry at rd_ptr and carry no meaning.
- Redirect has the highest priority. On that edge, count, wr_ptr and rd_ptr go to 0, fetch_pc takes {redirect_addr[0:29], 2'b00}, and no push occurs. An accepted pop in the same cycle is still consumed by IF.
- fetch_enable = 0 blocks pushes only. Pops and redirect still act.
- No operation decode and no branch prediction. Instruction bits pass through unmodified, including X values.
- Bit order is big-endian, index 0 = MSB, matching the processor's buses.

## Timing
- Reset (reset = 0, asynchronous): fetch_pc = RESET_PC, count = 0, wr_ptr = rd_ptr = 0, inst_valid = 0, imem_addr = RESET_PC. inst_out and pc_out read stored entries, which are not reset.
- Asserting reset at any time, including mid-stream with the queue full, clears the queue immediately without waiting for a clock edge. The first push happens on the first rising edge after reset returns to 1.
- Fetch-to-delivery latency is 1 cycle. The word sampled at edge k appears with inst_valid = 1 after edge k, if the queue was empty.
- Redirect latency: redirect sampled at edge k leaves the queue empty after k. The new target is pushed at edge k+1 and valid after k+1. Cycle-to-cycle bubble: 1.
- Steady state with inst_ready held at 1 gives 1 instruction per cycle. The queue stays at occupancy 1.
- Outputs inst_valid, inst_out, pc_out and count are functions of registered state only, with no combinational path from inst_ready. imem_addr is registered.

## Test plan
- **Reset and fill:** release reset with RESET_PC = 0, inst_ready = 0, imem word = address + 32'h1000_0000. After 4 edges, count = 4 and imem_addr = 16. Entries are (0, 0x10000000) through (12, 0x1000000C), and imem_addr then holds at 16.
- **Streaming:** inst_ready = 1 continuously. pc_out goes 0, 4, 8, … one per cycle, starting the cycle after reset release. count stays at 1 with no gaps.
- **Full with simultaneous push/pop:** with the queue full, pulse inst_ready for 1 cycle. pc_out 0 is accepted, 16 is pushed in the same edge, count stays 4, and imem_addr becomes 20.
- **Redirect mid-stream:** with count = 3, assert redirect (redirect_addr = 32'h0000_0103) together with inst_ready. The head pop completes and count = 0 after that edge. The next edge pushes pc 32'h100, and pc_out = 32'h100 with inst_valid = 1.
- **PC wrap:** redirect to 32'hFFFF_FFF8 with streaming. pc_out sequence is FFFF_FFF8, FFFF_FFFC, 0000_0000. Pointers wrap past DEPTH-1 with no corruption.
- **Async reset mid-operation:** drop reset between edges with count = 4. inst_valid and count fall to 0 before the next edge, and imem_addr = RESET_PC. After release, fetching restarts at RESET_PC.
